// File: rtl/mul_share_arb.sv
// mul_share_arb
//   Arbitrates NREQ requesters onto one shared, fully pipelined radix-4 Booth
//   multiplier that lives outside this block. Every state element updates on
//   the falling edge of clk so the arbiter sits in the multiplier's domain.
//
//   Handshake: req_ready is combinational and one-hot-or-zero. A requester is
//   issued when req_valid[i] & req_ready[i] are both high at a falling edge.
//   The arbiter never stalls: the pipeline accepts one issue per edge, and
//   responses carry no backpressure (rsp_valid is a one-edge pulse).
//
//   Timing for an issue at edge E0:
//     E0          operands land in mul_a/mul_b, stage-0 tag valid
//     E1..E(LAT)  tag shifts through LAT registers while the multiplier works
//     E(LAT+1)    rsp_valid/rsp_id presented; rsp_data = mul_product
//
//   Configuration macro:
//     MUL_SHARE_ARB_RR_EN  defined   -> round-robin priority pointer
//                          undefined -> fixed priority, lowest index wins
//
// Ports
//   clk          clock, falling-edge active
//   rst          asynchronous reset, active low
//   en           grant enable; low blocks new grants, in-flight work drains
//   req_valid    per-requester operand valid            [NREQ]
//   req_a/req_b  packed operands, requester i at [i*N +: N]
//   req_ready    one-hot-or-zero grant                  [NREQ]
//   mul_a/mul_b  registered operands to the multiplier  [N]
//   mul_product  product from the multiplier            [2N]
//   rsp_valid    response valid pulse
//   rsp_id       requester owning the response
//   rsp_data     mul_product while rsp_valid, else zero [2N]
//   busy         any operation in flight

module mul_share_arb #(
    parameter int NREQ = 4,
    parameter int N    = 12,
    parameter int LAT  = 4,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [N-1:0]      mul_a,
    output logic [N-1:0]      mul_b,
    input  logic [2*N-1:0]    mul_product,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [2*N-1:0]    rsp_data,
    output logic              busy
);

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            found;
    logic            hs;

    // Stage 0 travels with mul_a/mul_b; tag stages follow the multiplier.
    logic            s0_v;
    logic [IDW-1:0]  s0_id;
    logic [LAT-1:0]  tag_v;
    logic [IDW-1:0]  tag_id [LAT];

`ifdef MUL_SHARE_ARB_RR_EN
    logic [IDW-1:0]  ptr;
    logic [IDW:0]    rr_sum;
    logic [IDW-1:0]  rr_sel;

    // Search starting at ptr, wrapping at NREQ (need not be a power of two).
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        rr_sum   = '0;
        rr_sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            rr_sum = {1'b0, ptr} + (IDW+1)'(k);
            if (rr_sum >= (IDW+1)'(NREQ)) begin
                rr_sum = rr_sum - (IDW+1)'(NREQ);
            end
            rr_sel = rr_sum[IDW-1:0];
            if (!found && req_valid[rr_sel]) begin
                found          = 1'b1;
                grant[rr_sel]  = 1'b1;
                grant_id       = rr_sel;
            end
        end
    end

    // Pointer moves past the winner only when a handshake actually happens.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (hs) begin
            if (grant_id == IDW'(NREQ-1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_id + 1'b1;
            end
        end
    end
`else
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[IDW'(k)]) begin
                found              = 1'b1;
                grant[IDW'(k)]     = 1'b1;
                grant_id           = IDW'(k);
            end
        end
    end
`endif

    // rst is folded in so nothing is offered while the block is held in reset.
    assign req_ready = grant & {NREQ{en & rst}};
    assign hs        = |req_ready;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            mul_a     <= '0;
            mul_b     <= '0;
            s0_v      <= 1'b0;
            s0_id     <= '0;
            tag_v     <= '0;
            for (int k = 0; k < LAT; k++) begin
                tag_id[k] <= '0;
            end
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
        end else begin
            // Idle edges load zero so the multiplier sees clean operands.
            if (hs) begin
                mul_a <= req_a[int'(grant_id)*N +: N];
                mul_b <= req_b[int'(grant_id)*N +: N];
                s0_id <= grant_id;
            end else begin
                mul_a <= '0;
                mul_b <= '0;
                s0_id <= '0;
            end
            s0_v <= hs;

            tag_v[0]  <= s0_v;
            tag_id[0] <= s0_id;
            for (int k = 1; k < LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end

            rsp_valid <= tag_v[LAT-1];
            rsp_id    <= tag_v[LAT-1] ? tag_id[LAT-1] : '0;
        end
    end

    assign rsp_data = rsp_valid ? mul_product : '0;
    assign busy     = s0_v | (|tag_v);

endmodule
